uart_rx_oversample: RTL



---
 rtl/uart_rx_oversample.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
//
// UART receiver driven by a 16x-oversampled baud tick. Recovers frames made of
// one start bit, NB_DATA data bits (LSB first) and a stop period of SB_TICK
// oversample ticks from the asynchronous line i_rx. Each completed frame is
// presented as a registered data word with a one-cycle done strobe and a frame
// error flag (stop bit sampled low).
//
// Ports:
//   i_clk           system clock, all logic on the rising edge
//   i_reset         synchronous, active-low reset
//   i_s_tick        16x baud tick, one i_clk cycle wide
//   i_rx            asynchronous serial line, idle high
//   o_dout          last received data word (holds until the next frame)
//   o_rx_done_tick  one-cycle pulse, o_dout/o_frame_err updated
//   o_frame_err     stop bit sampled low on the last frame
// -----------------------------------------------------------------------------
module uart_rx_oversample #(
  parameter int NB_DATA  = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_dout,
  output logic               o_rx_done_tick,
  output logic               o_frame_err
);

  localparam int NB_CNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  typedef enum logic [NB_STATE-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Synchronizer flops; they reset high so a reset never looks like a start bit.
  logic rx_sync_p0;
  logic rx_sync_p1;
  logic rx_s;

  state_t              state_q, state_d;
  logic [4:0]          s_q, s_d;
  logic [NB_CNT-1:0]   n_q, n_d;
  logic [NB_DATA-1:0]  b_q, b_d;
  logic                done_d;

  logic [NB_DATA-1:0]  dout_q;
  logic                ferr_q;
  logic                done_q;

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous line ----
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= i_rx;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_s = rx_sync_p1;

  // ---- receiver state register ----
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      s_q     <= 5'd0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  // Next-state logic. Everything except the IDLE start detection waits for
  // a tick; the tick seen in the same cycle as IDLE->START is not counted
  // because IDLE ignores it.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = 5'd0;
        end
      end

      START: begin
        if (i_s_tick) begin
          // Eight ticks in is the middle of the start bit; a high line here
          // means the falling edge was a glitch.
          if (s_q == 5'd7) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = 5'd0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          // Sixteen ticks after mid-start lands in the middle of each data bit.
          if (s_q == 5'd15) begin
            s_d = 5'd0;
            b_d = {rx_s, b_q[NB_DATA-1:1]};
            if (n_q == NB_CNT'(NB_DATA - 1)) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      STOP: begin
        if (i_s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- output register: loaded on the same edge that returns to IDLE ----
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      dout_q <= '0;
      ferr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (done_d) begin
        dout_q <= b_q;
        ferr_q <= ~rx_s;
      end
    end
  end

  assign o_dout         = dout_q;
  assign o_frame_err    = ferr_q;
  assign o_rx_done_tick = done_q;

endmodule
